// File: rtl/fpnew_opgroup_out_arbiter_pkg.sv
// Shared types and helpers for the operation-group output arbiter.
// Holds the IEEE status flag record, the index-width helper and the
// round-robin winner search used by the arbiter sub-module.
package fpnew_opgroup_out_arbiter_pkg;

    // IEEE 754 exception flags, NX in the least significant bit.
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    localparam int unsigned STATUS_W = 5;

    // Upper bound on the number of requesters handled by rr_next.
    localparam int unsigned MaxReq  = 32;
    localparam int unsigned MaxReqW = 5;

    // Width of an index into n elements, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester at or after ptr, wrapping modulo n.
    // Returns 0 when nothing requests; callers qualify with |req.
    function automatic int unsigned rr_next(input int unsigned       ptr,
                                            input logic [MaxReq-1:0] req,
                                            input int unsigned       n);
        int unsigned winner;
        int unsigned idx;
        logic        found;
        winner = 0;
        found  = 1'b0;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            if ((k < n) && !found) begin
                idx = (ptr + k) % n;
                if (req[idx[MaxReqW-1:0]]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/fpnew_opgroup_out_arbiter_if.sv
// Bundle of the per-slice handshakes and the registered output stage
// of the operation-group arbiter. The DUT uses the slave side, the
// slice/result-mux environment uses the master side.
interface fpnew_opgroup_out_arbiter_if
    import fpnew_opgroup_out_arbiter_pkg::*;
#(
    parameter int unsigned NumInputs = 5,
    parameter int unsigned Width     = 64,
    parameter type         TagType   = logic
) ();

    localparam int unsigned IdxWidth = idx_width(NumInputs);

    // Slice side
    logic    [NumInputs-1:0][Width-1:0] slice_result_i;
    status_t [NumInputs-1:0]            slice_status_i;
    logic    [NumInputs-1:0]            slice_ext_bit_i;
    TagType  [NumInputs-1:0]            slice_tag_i;
    logic    [NumInputs-1:0]            slice_valid_i;
    logic    [NumInputs-1:0]            slice_ready_o;

    // Output register side
    logic    [Width-1:0]                result_o;
    status_t                            status_o;
    logic                               extension_bit_o;
    TagType                             tag_o;
    logic    [IdxWidth-1:0]             src_idx_o;
    logic                               out_valid_o;
    logic                               out_ready_i;

    modport slave (
        input  slice_result_i,
        input  slice_status_i,
        input  slice_ext_bit_i,
        input  slice_tag_i,
        input  slice_valid_i,
        output slice_ready_o,
        output result_o,
        output status_o,
        output extension_bit_o,
        output tag_o,
        output src_idx_o,
        output out_valid_o,
        input  out_ready_i
    );

    modport master (
        output slice_result_i,
        output slice_status_i,
        output slice_ext_bit_i,
        output slice_tag_i,
        output slice_valid_i,
        input  slice_ready_o,
        input  result_o,
        input  status_o,
        input  extension_bit_o,
        input  tag_o,
        input  src_idx_o,
        input  out_valid_o,
        output out_ready_i
    );

endinterface

// File: rtl/fpnew_rr_arbiter.sv
// Round-robin arbiter with its own priority pointer.
// The pointer moves one past the winner whenever the caller reports that
// the grant was actually consumed, and returns to 0 on flush.
module fpnew_rr_arbiter
    import fpnew_opgroup_out_arbiter_pkg::*;
#(
    parameter  int unsigned NumReq   = 5,
    localparam int unsigned IdxWidth = idx_width(NumReq)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   req_i,
    input  logic                advance_i,
    input  logic                flush_i,
    output logic [NumReq-1:0]   grant_o,
    output logic [IdxWidth-1:0] grant_idx_o,
    output logic                grant_valid_o
);

    logic [IdxWidth-1:0] ptr_q, ptr_d;
    int unsigned         winner;

    // Search for the first requester starting at the pointer.
    always_comb begin
        winner        = rr_next(32'(ptr_q), MaxReq'(req_i), NumReq);
        grant_valid_o = |req_i;
        grant_idx_o   = IdxWidth'(winner);
        grant_o       = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            grant_o[i] = grant_valid_o && (winner == i);
        end
    end

    // Next pointer: flush wins, otherwise step past a consumed winner.
    // With a single requester winner+1 always equals NumReq, so ptr stays 0.
    always_comb begin
        ptr_d = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
        end else if (advance_i) begin
            if ((winner + 1) == NumReq) begin
                ptr_d = '0;
            end else begin
                ptr_d = IdxWidth'(winner + 1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpnew_opgroup_out_arbiter.sv
// Output arbiter of one FPU operation group.
// Picks one of the per-format slice results round-robin and holds it in a
// single-entry register toward the FPU result mux. A slot can be refilled
// in the same cycle it drains, giving one result per cycle at 1-cycle latency.
module fpnew_opgroup_out_arbiter
    import fpnew_opgroup_out_arbiter_pkg::*;
#(
    parameter  int unsigned NumInputs = 5,
    parameter  int unsigned Width     = 64,
    parameter  type         TagType   = logic,
    localparam int unsigned IdxWidth  = idx_width(NumInputs)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    output logic                         busy_o,
    fpnew_opgroup_out_arbiter_if.slave   bus
);

    logic [NumInputs-1:0] grant;
    logic [IdxWidth-1:0]  grant_idx;
    logic                 grant_valid;
    logic                 accept;
    logic                 fire;

    logic [Width-1:0]     sel_result;
    status_t              sel_status;
    logic                 sel_ext;
    TagType               sel_tag;

    logic                 out_valid_q, out_valid_d;
    logic [Width-1:0]     result_q,    result_d;
    status_t              status_q,    status_d;
    logic                 ext_bit_q,   ext_bit_d;
    TagType               tag_q,       tag_d;
    logic [IdxWidth-1:0]  src_idx_q,   src_idx_d;

    // Register slot is free when empty or being drained this cycle.
    assign accept = ~out_valid_q | bus.out_ready_i;
    // A slice handshake happens only for the granted slice, never during flush.
    assign fire   = grant_valid & accept & ~flush_i;

    fpnew_rr_arbiter #(
        .NumReq (NumInputs)
    ) i_rr_arbiter (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (bus.slice_valid_i),
        .advance_i     (fire),
        .flush_i       (flush_i),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign bus.slice_ready_o = grant & {NumInputs{accept & ~flush_i}};

    // One-hot AND-OR mux of the granted slice's payload.
    always_comb begin
        sel_result = '0;
        sel_status = '0;
        sel_ext    = 1'b0;
        sel_tag    = '0;
        for (int unsigned i = 0; i < NumInputs; i++) begin
            if (grant[i]) begin
                sel_result = bus.slice_result_i[i];
                sel_status = bus.slice_status_i[i];
                sel_ext    = bus.slice_ext_bit_i[i];
                sel_tag    = bus.slice_tag_i[i];
            end
        end
    end

    // Output slot update: flush empties it, a handshake loads it,
    // a drain with nothing to refill clears valid but keeps the data.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        status_d    = status_q;
        ext_bit_d   = ext_bit_q;
        tag_d       = tag_q;
        src_idx_d   = src_idx_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d = 1'b1;
            result_d    = sel_result;
            status_d    = sel_status;
            ext_bit_d   = sel_ext;
            tag_d       = sel_tag;
            src_idx_d   = grant_idx;
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Output slot registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
            ext_bit_q   <= 1'b0;
            tag_q       <= '0;
            src_idx_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            status_q    <= status_d;
            ext_bit_q   <= ext_bit_d;
            tag_q       <= tag_d;
            src_idx_q   <= src_idx_d;
        end
    end

    assign bus.out_valid_o     = out_valid_q;
    assign bus.result_o        = result_q;
    assign bus.status_o        = status_q;
    assign bus.extension_bit_o = ext_bit_q;
    assign bus.tag_o           = tag_q;
    assign bus.src_idx_o       = src_idx_q;

    assign busy_o = out_valid_q | (|bus.slice_valid_i);

endmodule

// File: tb/tb_fpnew_opgroup_out_arbiter.sv
// Self-checking bench for fpnew_opgroup_out_arbiter with a transaction-level
// reference model of the round-robin output slot.
module tb_fpnew_opgroup_out_arbiter;
    import fpnew_opgroup_out_arbiter_pkg::*;

    localparam int N = 5;
    localparam int W = 64;
    typedef logic [7:0] tag_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;

    fpnew_opgroup_out_arbiter_if #(.NumInputs(N), .Width(W), .TagType(tag_t)) bus ();

    fpnew_opgroup_out_arbiter #(.NumInputs(N), .Width(W), .TagType(tag_t)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .busy_o  (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit             m_vld;
    logic [W-1:0]   m_res;
    logic [4:0]     m_st;
    logic           m_ext;
    tag_t           m_tag;
    int             m_src;
    int             m_ptr;
    logic [N-1:0]   last_rdy;

    task automatic model_reset();
        m_vld = 0; m_res = '0; m_st = '0; m_ext = 1'b0; m_tag = '0; m_src = 0; m_ptr = 0;
    endtask

    // Winner by the round-robin rule: first valid slice counting up from ptr.
    function automatic int exp_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (bus.slice_valid_i[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = exp_grant();
        if (g >= 0 && (!m_vld || bus.out_ready_i) && !flush) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock: predict from the inputs, then let the DUT clock.
    task automatic tick();
        int g;
        g = exp_grant();
        last_rdy = exp_ready();
        @(posedge clk); #1;
        if (flush) begin
            m_vld = 0; m_ptr = 0;
        end else if (last_rdy != '0) begin
            m_vld = 1;
            m_res = bus.slice_result_i[g];
            m_st  = bus.slice_status_i[g];
            m_ext = bus.slice_ext_bit_i[g];
            m_tag = bus.slice_tag_i[g];
            m_src = g;
            m_ptr = (g + 1) % N;
        end else if (bus.out_ready_i) begin
            m_vld = 0;
        end
    endtask

    task automatic set_slice(input int i, input bit v);
        bus.slice_valid_i[i]   = v;
        bus.slice_result_i[i]  = {$urandom, $urandom};
        bus.slice_status_i[i]  = status_t'(5'($urandom));
        bus.slice_ext_bit_i[i] = 1'($urandom);
        bus.slice_tag_i[i]     = 8'($urandom);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) set_slice(i, 1'b0);
        bus.out_ready_i = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #12;
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.out_valid_o); end
        checks++; if (bus.result_o !== '0) begin errors++; $display("FAIL reset_result got=%h want=0", bus.result_o); end
        checks++; if (bus.status_o !== 5'b0 || bus.extension_bit_o !== 1'b0 || bus.tag_o !== 8'h0) begin
            errors++; $display("FAIL reset_fields st=%b ext=%b tag=%h want 0", bus.status_o, bus.extension_bit_o, bus.tag_o); end
        checks++; if (bus.src_idx_o !== 3'd0) begin errors++; $display("FAIL reset_src got=%0d want=0", bus.src_idx_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_single();
        bus.slice_valid_i[2]   = 1'b1;
        bus.slice_result_i[2]  = 64'h3FF0_0000_0000_0000;
        bus.slice_status_i[2]  = status_t'(5'b00001);
        bus.slice_ext_bit_i[2] = 1'b1;
        bus.slice_tag_i[2]     = 8'hA5;
        bus.out_ready_i = 1'b1;
        #1;
        checks++; if (bus.slice_ready_o !== 5'b00100) begin errors++; $display("FAIL single_ready got=%b want=00100", bus.slice_ready_o); end
        tick();
        bus.slice_valid_i[2] = 1'b0;
        checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", bus.out_valid_o); end
        checks++; if (bus.result_o !== 64'h3FF0_0000_0000_0000) begin errors++; $display("FAIL single_result got=%h want=3ff0000000000000", bus.result_o); end
        checks++; if (bus.src_idx_o !== 3'd2) begin errors++; $display("FAIL single_src got=%0d want=2", bus.src_idx_o); end
        checks++; if (bus.status_o !== 5'b00001 || bus.tag_o !== 8'hA5 || bus.extension_bit_o !== 1'b1) begin
            errors++; $display("FAIL single_fields st=%b tag=%h ext=%b want 00001 a5 1", bus.status_o, bus.tag_o, bus.extension_bit_o); end
    endtask

    task automatic test_drain();
        bus.out_ready_i = 1'b1;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_before got=%b want=1", busy); end
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b want=0", bus.out_valid_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy got=%b want=0", busy); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] e;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < N; i++) set_slice(i, 1'b1);
        for (int c = 0; c < 6; c++) begin
            int exp;
            exp = c % N;
            e = '0; e[exp] = 1'b1;
            #1;
            checks++; if (bus.slice_ready_o !== e) begin errors++; $display("FAIL rr_ready cycle=%0d got=%b want=%b", c, bus.slice_ready_o, e); end
            tick();
            checks++; if (bus.out_valid_o !== 1'b1 || bus.src_idx_o !== 3'(exp) || bus.result_o !== m_res) begin
                errors++; $display("FAIL rr_out cycle=%0d vld=%b src=%0d res=%h want vld=1 src=%0d res=%h",
                                   c, bus.out_valid_o, bus.src_idx_o, bus.result_o, exp, m_res); end
            set_slice(exp, 1'b1);
        end
        for (int i = 0; i < N; i++) bus.slice_valid_i[i] = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        set_slice(1, 1'b1);
        bus.out_ready_i = 1'b1;
        held = bus.slice_result_i[1];
        #1;
        checks++; if (bus.slice_ready_o !== 5'b00010) begin errors++; $display("FAIL bp_load_ready got=%b want=00010", bus.slice_ready_o); end
        tick();
        bus.slice_valid_i[1] = 1'b0;
        set_slice(0, 1'b1);
        set_slice(3, 1'b1);
        bus.out_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (bus.slice_ready_o !== 5'b00000) begin errors++; $display("FAIL bp_ready cycle=%0d got=%b want=00000", c, bus.slice_ready_o); end
            tick();
            checks++; if (bus.out_valid_o !== 1'b1 || bus.src_idx_o !== 3'd1 || bus.result_o !== held) begin
                errors++; $display("FAIL bp_hold cycle=%0d vld=%b src=%0d res=%h want vld=1 src=1 res=%h",
                                   c, bus.out_valid_o, bus.src_idx_o, bus.result_o, held); end
        end
        bus.out_ready_i = 1'b1;
        #1;
        checks++; if (bus.slice_ready_o !== 5'b01000) begin errors++; $display("FAIL bp_release1 got=%b want=01000", bus.slice_ready_o); end
        tick();
        checks++; if (bus.src_idx_o !== 3'd3) begin errors++; $display("FAIL bp_src1 got=%0d want=3", bus.src_idx_o); end
        bus.slice_valid_i[3] = 1'b0;
        #1;
        checks++; if (bus.slice_ready_o !== 5'b00001) begin errors++; $display("FAIL bp_release2 got=%b want=00001", bus.slice_ready_o); end
        tick();
        checks++; if (bus.src_idx_o !== 3'd0) begin errors++; $display("FAIL bp_src2 got=%0d want=0", bus.src_idx_o); end
        bus.slice_valid_i[0] = 1'b0;
    endtask

    task automatic test_flush();
        set_slice(4, 1'b1);
        bus.out_ready_i = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (bus.slice_ready_o !== 5'b00000) begin errors++; $display("FAIL flush_ready got=%b want=00000", bus.slice_ready_o); end
        tick();
        flush = 1'b0;
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b want=0", bus.out_valid_o); end
        set_slice(0, 1'b1);
        #1;
        checks++; if (bus.slice_ready_o !== 5'b00001) begin errors++; $display("FAIL flush_ptr got=%b want=00001", bus.slice_ready_o); end
        tick();
        bus.slice_valid_i[0] = 1'b0;
        #1;
        checks++; if (bus.slice_ready_o !== 5'b10000) begin errors++; $display("FAIL flush_s4_ready got=%b want=10000", bus.slice_ready_o); end
        tick();
        checks++; if (bus.out_valid_o !== 1'b1 || bus.src_idx_o !== 3'd4) begin
            errors++; $display("FAIL flush_s4_out vld=%b src=%0d want vld=1 src=4", bus.out_valid_o, bus.src_idx_o); end
        bus.slice_valid_i[4] = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < N; i++) set_slice(i, 1'b1);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid_o !== 1'b0 || bus.src_idx_o !== 3'd0) begin
            errors++; $display("FAIL areset_ctrl vld=%b src=%0d want 0 0", bus.out_valid_o, bus.src_idx_o); end
        checks++; if (bus.result_o !== '0 || bus.status_o !== 5'b0 || bus.extension_bit_o !== 1'b0 || bus.tag_o !== 8'h0) begin
            errors++; $display("FAIL areset_fields res=%h st=%b ext=%b tag=%h want 0", bus.result_o, bus.status_o, bus.extension_bit_o, bus.tag_o); end
        model_reset();
        clear_inputs();
        set_slice(1, 1'b1);
        set_slice(3, 1'b1);
        bus.out_ready_i = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        #1;
        checks++; if (bus.slice_ready_o !== 5'b00010) begin errors++; $display("FAIL areset_grant got=%b want=00010", bus.slice_ready_o); end
        tick();
        checks++; if (bus.src_idx_o !== 3'd1 || bus.out_valid_o !== 1'b1) begin
            errors++; $display("FAIL areset_first src=%0d vld=%b want 1 1", bus.src_idx_o, bus.out_valid_o); end
        clear_inputs();
        bus.out_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.out_ready_i = (($urandom % 4) != 0);
            flush = (($urandom % 20) == 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.slice_valid_i[i] && (($urandom % 3) == 0)) set_slice(i, 1'b1);
            end
            #1;
            checks++; if (bus.slice_ready_o !== exp_ready()) begin
                errors++; $display("FAIL rand_ready cycle=%0d got=%b want=%b", c, bus.slice_ready_o, exp_ready()); end
            checks++; if (busy !== (m_vld | (|bus.slice_valid_i))) begin
                errors++; $display("FAIL rand_busy cycle=%0d got=%b want=%b", c, busy, m_vld | (|bus.slice_valid_i)); end
            tick();
            checks++; if (bus.out_valid_o !== m_vld) begin
                errors++; $display("FAIL rand_valid cycle=%0d got=%b want=%b", c, bus.out_valid_o, m_vld); end
            if (m_vld) begin
                checks++;
                if (bus.result_o !== m_res || bus.status_o !== m_st || bus.extension_bit_o !== m_ext ||
                    bus.tag_o !== m_tag || bus.src_idx_o !== 3'(m_src)) begin
                    errors++;
                    $display("FAIL rand_data cycle=%0d got res=%h st=%b ext=%b tag=%h src=%0d want res=%h st=%b ext=%b tag=%h src=%0d",
                             c, bus.result_o, bus.status_o, bus.extension_bit_o, bus.tag_o, bus.src_idx_o,
                             m_res, m_st, m_ext, m_tag, m_src);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (last_rdy[i]) set_slice(i, 1'($urandom));
            end
        end
    endtask

    initial begin
        model_reset();
        last_rdy = '0;
        test_reset();
        test_single();
        test_drain();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpnew_opgroup_out_arbiter.md
Name: fpnew_opgroup_out_arbiter

Overview:
- Downstream stage of the per-format operation slices within one operation group.
- Collects result/status/extension-bit/tag from NumInputs format slices via valid/ready, arbitrates round-robin, and registers the winner into a single-entry output stage feeding the FPU top-level result mux.
- Provides 1-cycle latency and full throughput under no backpressure.

Parameters:
- NumInputs, 5, number of format slices feeding this arbiter (>=1).
- Width, 64, result width in bits, equal to the slice Width.
- TagType, logic, type of the operation tag carried alongside each result.
- IdxWidth (localparam), max(1, $clog2(NumInputs)), width of the source index.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- slice_result_i  in  NumInputs x Width  per-slice result.
- slice_status_i  in  NumInputs x fpnew_pkg::status_t (5)  per-slice status {NV,DZ,OF,UF,NX}.
- slice_ext_bit_i  in  NumInputs  per-slice extension bit.
- slice_tag_i  in  NumInputs x TagType  per-slice tag.
- slice_valid_i  in  NumInputs  per-slice output valid.
- slice_ready_o  out  NumInputs  per-slice output ready.
- flush_i  in  1  synchronous flush.
- result_o  out  Width  registered result.
- status_o  out  status_t  registered status.
- extension_bit_o  out  1  registered extension bit.
- tag_o  out  TagType  registered tag.
- src_idx_o  out  IdxWidth  index of the slice that produced the held result.
- out_valid_o  out  1  output register valid.
- out_ready_i  in  1  downstream ready.
- busy_o  out  1  result held or any slice valid.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - out_valid_o=0.
  - result_o, status_o, extension_bit_o, tag_o, src_idx_o = 0.
  - Round-robin pointer ptr=0.
- Output register can accept when `accept = ~out_valid_o | out_ready_i`.
- Arbitration, combinational:
  - Grant goes to the first i with slice_valid_i[i]=1, scanning ptr, ptr+1, ..., NumInputs-1, 0, ..., ptr-1 (modulo NumInputs).
  - At most one grant. No grant if no input is valid.
- Ready rules:
  - slice_ready_o[i] = grant[i] & accept & ~flush_i.
  - Ready must not depend on out_valid_o of another cycle beyond the accept term.
  - Ungranted valid slices hold their data (their own handshake contract).
- Handshake with slice i (valid & ready):
  - Next edge: register captures result/status/ext/tag, src_idx_o=i, out_valid_o=1.
  - ptr = (i+1) mod NumInputs.
  - Wrap: i=NumInputs-1 gives ptr=0.
- Drain without refill (out_valid_o & out_ready_i & no grant): out_valid_o=0 next edge. Data fields keep their last value.
- Simultaneous drain and refill: register is overwritten with the new winner; out_valid_o stays 1. This sustains one result per cycle.
- Backpressure (out_valid_o=1, out_ready_i=0):
  - Register and ptr are frozen; all slice_ready_o=0.
  - out_valid_o and all fields stay stable until the handshake.
- flush_i=1:
  - No slice handshake that cycle.
  - Next edge: out_valid_o=0 and ptr=0. Data fields are don't-care (hold).
  - Flush overrides simultaneous drain/refill.
- NumInputs=1: ptr is constant 0; the block degenerates to a pipeline register with the same handshake rules.
- busy_o = out_valid_o | (|slice_valid_i).
- Latency: exactly 1 cycle from slice handshake to out_valid_o.
- Ordering: no inter-slice ordering guarantee beyond round-robin fairness. Tags carry identity.
- Fairness: a slice held valid waits at most NumInputs-1 grants.

Decomposition:
- fpnew_pkg:
  - reuse status_t.
  - add function `rr_next(ptr, req, n)` returning the winner index.
  - add constant helper `idx_width(n)` = max(1, clog2(n)).
- Sub-module fpnew_rr_arbiter (parameter NumReq):
  - Inputs: req vector, ptr, advance strobe, flush, clk_i/rst_ni.
  - Outputs: one-hot grant and grant index.
  - Owns the ptr register; same reset/flush rules as above.
- Top handles the output register, ready logic and the data mux.

Test Plan:
- Single slice 2 valid with result 0x3FF0_0000_0000_0000, status NX=1, out_ready_i=1:
  - slice_ready_o=5'b00100 the same cycle.
  - Next cycle out_valid_o=1, result matches, src_idx_o=2, status_o=5'b00001.
- All 5 slices held valid, out_ready_i=1, ptr=0:
  - Grants in order 0,1,2,3,4,0 on consecutive cycles; out_valid_o stays 1 throughout.
- Backpressure: register holds slice 1 data, out_ready_i=0 for 4 cycles, slices 0 and 3 valid:
  - slice_ready_o=0 and outputs stable for all 4 cycles.
  - Release gives grant 3 (ptr=2), then 0.
- Flush while out_valid_o=1 and slice 4 valid:
  - slice_ready_o=0 that cycle.
  - Next cycle out_valid_o=0 and ptr=0; slice 4 is granted afterward if still valid.
- Async reset asserted mid-stream between clock edges:
  - out_valid_o, src_idx_o and all fields are 0 immediately.
  - After deassertion the first grant goes to the lowest valid index.
- Drain with no new request: out_valid_o=1, out_ready_i=1, no slice valid → out_valid_o=0 next cycle and busy_o=0.
